// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write arbiter that funnels NUM_REQ producers into a
// single FIFO write port, with one write in flight and retry on rejection.
//
// Optional feature: define FIFO_WR_ARB_STATS_EN to add the retry_cnt output.
//
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   req         - per-producer write request (level, held until gnt)
//   req_data    - producer words, slice i = [i*FIFO_WIDTH +: FIFO_WIDTH]
//   gnt         - one-hot pulse: producer's word was acknowledged by the FIFO
//   wr_en       - FIFO write enable (registered, never two cycles in a row)
//   data_in     - FIFO write data (registered, held while wr_en is low)
//   full        - FIFO full flag
//   wr_ack      - FIFO write acknowledge, the cycle after wr_en
//   overflow    - FIFO rejected the write, the cycle after wr_en
//   busy        - high whenever the arbiter is not idle
//   retry_cnt   - (FIFO_WR_ARB_STATS_EN only) saturating count of retries
module fifo_wr_arb #(
   parameter int unsigned FIFO_WIDTH = 16,
   parameter int unsigned NUM_REQ    = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          wr_en,
   output logic [FIFO_WIDTH-1:0]         data_in,
   input  logic                          full,
   input  logic                          wr_ack,
   input  logic                          overflow,
   output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [15:0]                   retry_cnt
`endif
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_ACK = 2'd2,
      RETRY    = 2'd3
   } state_t;

   state_t                  r_state;
   logic [IDX_W-1:0]        r_idx;
   logic [IDX_W-1:0]        r_rr_ptr;
   logic [NUM_REQ-1:0]      r_gnt;
   logic                    r_wr_en;
   logic [FIFO_WIDTH-1:0]   r_data_in;
   logic                    r_busy;

   logic [NUM_REQ-1:0]      w_req_eff;
   logic                    w_found;
   logic [IDX_W-1:0]        w_win;
   logic [IDX_W-1:0]        w_cand;
   logic [FIFO_WIDTH-1:0]   w_win_data;
   logic [IDX_W-1:0]        w_rr_next;
   logic                    w_accepted;

   // A producer sees gnt one cycle before it can drop req; mask it so the
   // just-granted word is not written a second time.
   always_comb begin
      w_req_eff = req & ~r_gnt;
      w_found   = 1'b0;
      w_win     = '0;
      w_cand    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_cand = IDX_W'((32'(r_rr_ptr) + i) % NUM_REQ);
         if (!w_found && w_req_eff[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   // Winner word, next round-robin pointer and write acceptance
   always_comb begin
      w_win_data = req_data[32'(w_win)*FIFO_WIDTH +: FIFO_WIDTH];
      w_rr_next  = IDX_W'((32'(r_idx) + 32'd1) % NUM_REQ);
      // An ack that arrives together with overflow is not trusted as accepted.
      w_accepted = wr_ack && !overflow;
   end

   // Arbiter FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_rr_ptr  <= '0;
         r_gnt     <= '0;
         r_wr_en   <= 1'b0;
         r_data_in <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_gnt   <= '0;
         r_wr_en <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_found && !full) begin
                  r_idx     <= w_win;
                  r_data_in <= w_win_data;
                  r_wr_en   <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= ISSUE;
               end
            end
            ISSUE: begin
               r_state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (w_accepted) begin
                  r_gnt    <= NUM_REQ'(1) << r_idx;
                  r_rr_ptr <= w_rr_next;
                  r_busy   <= 1'b0;
                  r_state  <= IDLE;
               end else begin
                  r_state <= RETRY;
               end
            end
            RETRY: begin
               if (!full) begin
                  r_wr_en <= 1'b1;
                  r_state <= ISSUE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0] r_retry_cnt;

   // Saturating count of WAIT_ACK -> RETRY transitions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retry_cnt <= '0;
      end else if (r_state == WAIT_ACK && !w_accepted && r_retry_cnt != 16'hFFFF) begin
         r_retry_cnt <= r_retry_cnt + 16'd1;
      end
   end

   assign retry_cnt = r_retry_cnt;
`endif

   assign gnt     = r_gnt;
   assign wr_en   = r_wr_en;
   assign data_in = r_data_in;
   assign busy    = r_busy;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: scoreboard bench for fifo_wr_arb. Stimulus pushes expected
// FIFO writes and grants into queues; a monitor pops and compares them.
module tb_fifo_wr_arb;

   localparam int unsigned W = 16;
   localparam int unsigned N = 4;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*W-1:0]  req_data;
   logic [N-1:0]    gnt;
   logic            wr_en;
   logic [W-1:0]    data_in;
   logic            full;
   logic            wr_ack;
   logic            overflow;
   logic            busy;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0]     retry_cnt;
`endif

   fifo_wr_arb #(.FIFO_WIDTH(W), .NUM_REQ(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .wr_en    (wr_en),
      .data_in  (data_in),
      .full     (full),
      .wr_ack   (wr_ack),
      .overflow (overflow),
      .busy     (busy)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .retry_cnt(retry_cnt)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;
   int ncyc    = 0;
   logic ack_mode = 1'b1;

   logic [W-1:0] exp_wr[$];
   logic [N-1:0] exp_gnt[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) ncyc <= ncyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_data(input int i, input logic [W-1:0] v);
      req_data[i*W +: W] = v;
   endtask

   // FIFO model: answers each write in the following cycle
   initial begin
      logic p;
      wr_ack   = 1'b0;
      overflow = 1'b0;
      forever begin
         @(negedge clk);
         p = wr_en;
         @(posedge clk);
         #1;
         wr_ack   = p & ack_mode;
         overflow = p & ~ack_mode;
      end
   end

   // Monitor: compares every write and grant against the scoreboard
   initial begin
      logic prev_wr = 1'b0;
      int   last_wr = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_wr = 1'b0;
         end else begin
            if (wr_en) begin
               chk("wr_en_back_to_back", 32'(prev_wr), 32'd0);
               if (exp_wr.size() == 0) chk("unexpected_write", 32'(data_in), 32'hFFFF_FFFF);
               else chk("data_in", 32'(data_in), 32'(exp_wr.pop_front()));
               last_wr = ncyc;
            end
            if (gnt != '0) begin
               if (exp_gnt.size() == 0) chk("unexpected_gnt", 32'(gnt), 32'hFFFF_FFFF);
               else chk("gnt", 32'(gnt), 32'(exp_gnt.pop_front()));
               chk("gnt_latency", 32'(ncyc - last_wr), 32'd2);
            end
            prev_wr = wr_en;
         end
      end
   end

   task automatic wait_gnt(output int cyc);
      cyc = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (gnt != '0) begin
            cyc = ncyc;
            return;
         end
      end
      chk("timeout_gnt", 32'd0, 32'd1);
   endtask

   task automatic wait_wr(output int cyc);
      cyc = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (wr_en) begin
            cyc = ncyc;
            return;
         end
      end
      chk("timeout_wr", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_data_in", 32'(data_in), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1, cp;
      rst_n    = 1'b0;
      req      = '0;
      req_data = '0;
      full     = 1'b0;
      do_reset();

      // Single producer, acked write
      set_data(0, 16'hA5A5);
      exp_wr.push_back(16'hA5A5);
      exp_gnt.push_back(4'b0001);
      req = 4'b0001;
      wait_gnt(c0);
      req = '0;

      // All producers requesting: grants 0,1,2,3,0 every 3 cycles
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 4; i++) set_data(i, 16'(16'h1000 + i));
      for (int i = 0; i < 5; i++) begin
         exp_wr.push_back(16'(16'h1000 + (i % 4)));
         exp_gnt.push_back(4'(1 << (i % 4)));
      end
      req = 4'b1111;
      cp = 0;
      for (int i = 0; i < 5; i++) begin
         wait_gnt(c0);
         if (i > 0) chk("gnt_spacing", 32'(c0 - cp), 32'd3);
         cp = c0;
      end
      req = '0;

      // FIFO full blocks arbitration; release issues promptly
      @(negedge clk);
      full = 1'b1;
      set_data(1, 16'h5A01);
      req = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("full_wr_en", 32'(wr_en), 32'd0);
         chk("full_busy", 32'(busy), 32'd0);
      end
      exp_wr.push_back(16'h5A01);
      exp_gnt.push_back(4'b0010);
      full = 1'b0;
      c0 = ncyc;
      wait_wr(c1);
      chk("full_release_latency", 32'((c1 - c0) <= 2), 32'd1);
      wait_gnt(c0);
      req = '0;

      // Overflow, full held for 5 cycles, then reissue of the same word
      @(negedge clk);
      ack_mode = 1'b0;
      set_data(2, 16'h3C3C);
      exp_wr.push_back(16'h3C3C);
      exp_wr.push_back(16'h3C3C);
      exp_gnt.push_back(4'b0100);
      req = 4'b0100;
      wait_wr(c1);
      full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("retry_busy", 32'(busy), 32'd1);
         chk("retry_wr_en", 32'(wr_en), 32'd0);
         chk("retry_gnt", 32'(gnt), 32'd0);
      end
      ack_mode = 1'b1;
      full = 1'b0;
      wait_gnt(c0);
      req = '0;
`ifdef FIFO_WR_ARB_STATS_EN
      chk("retry_cnt", 32'(retry_cnt), 32'd1);
`endif

      // Reset during WAIT_ACK discards the word; rr pointer restarts at 0
      @(negedge clk);
      set_data(3, 16'hDEAD);
      exp_wr.push_back(16'hDEAD);
      req = 4'b1000;
      wait_wr(c1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_wr_en", 32'(wr_en), 32'd0);
      chk("async_rst_gnt", 32'(gnt), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
      chk("async_rst_retry_cnt", 32'(retry_cnt), 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      set_data(2, 16'h0F0F);
      exp_wr.push_back(16'h0F0F);
      exp_gnt.push_back(4'b0100);
      exp_wr.push_back(16'hDEAD);
      exp_gnt.push_back(4'b1000);
      req = 4'b1100;
      wait_gnt(c0);
      req = 4'b1000;
      wait_gnt(c0);
      req = '0;

      repeat (4) @(negedge clk);
      chk("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
      chk("exp_gnt_drained", 32'(exp_gnt.size()), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
